// File: rtl/serial_sequence_generator_pkg.sv
// Shared constants for the serial sequence generator: FSM encoding, default
// pattern and the repeat-count normalisation helper.
package seq_gen_pkg;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] SEND = 2'b01;
  localparam logic [1:0] GAP  = 2'b10;
  localparam logic [1:0] DONE = 2'b11;

  localparam logic [4:0] SEQ_DEFAULT_PAT = 5'b01110;

  // A requested repeat count of zero still sends the pattern once.
  function automatic logic [31:0] rep_at_least_one(input logic [31:0] rep);
    return (rep == 32'd0) ? 32'd1 : rep;
  endfunction

endpackage

// File: rtl/serial_sequence_generator_if.sv
// Control/status bundle of the serial sequence generator; the slave modport
// is the generator side, the master modport the side that drives transfers.
interface serial_sequence_generator_if #(
  parameter int PAT_W = 5,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
);
  logic             i_Start;
  logic             i_Abort;
  logic             i_Use_Default;
  logic [PAT_W-1:0] i_Pattern;
  logic [CNT_W-1:0] i_Repeat;
  logic [GAP_W-1:0] i_Gap;
  logic             o_Sequence;
  logic             o_Valid;
  logic             o_Frame_Start;
  logic             o_Busy;
  logic             o_Done;

  modport master (
    output i_Start, i_Abort, i_Use_Default, i_Pattern, i_Repeat, i_Gap,
    input  o_Sequence, o_Valid, o_Frame_Start, o_Busy, o_Done
  );

  modport slave (
    input  i_Start, i_Abort, i_Use_Default, i_Pattern, i_Repeat, i_Gap,
    output o_Sequence, o_Valid, o_Frame_Start, o_Busy, o_Done
  );
endinterface

// File: rtl/serial_sequence_generator_shifter.sv
// Load/shift-left register presenting its MSB; the generator's bit source.
module pattern_shifter #(
  parameter int PAT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [PAT_W-1:0] data_i,
  output logic             msb_o
);
  logic [PAT_W-1:0] sr_q;

  // NOTE: sequential state is assigned with <= so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= data_i;
    end else if (shift_i) begin
      sr_q <= {sr_q[PAT_W-2:0], 1'b0};
    end
  end

  assign msb_o = sr_q[PAT_W-1];
endmodule

// File: rtl/serial_sequence_generator.sv
// Serial pattern transmitter: sends a latched PAT_W-bit pattern MSB-first for
// a number of repetitions separated by idle gaps; all outputs registered.
module serial_sequence_generator
  import seq_gen_pkg::*;
#(
  parameter int               PAT_W       = 5,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = SEQ_DEFAULT_PAT,
  parameter int               CNT_W       = 8,
  parameter int               GAP_W       = 4,
  parameter logic             IDLE_LVL    = 1'b1
) (
  input logic                         i_Clk,
  input logic                         i_Rst_n,
  serial_sequence_generator_if.slave  bus
);
  localparam int BIT_W = $clog2(PAT_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);

  logic [1:0]       state_q, state_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [GAP_W-1:0] gap_len_q, gap_len_d;
  logic [CNT_W-1:0] reps_q, reps_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             seq_q, seq_d, valid_q, valid_d, frame_q, frame_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             sh_load, sh_shift, sh_msb, start_ok, sending;
  logic [PAT_W-1:0] sh_data, new_pat;

  pattern_shifter #(.PAT_W(PAT_W)) u_shifter (
    .clk     (i_Clk),
    .rst_n   (i_Rst_n),
    .load_i  (sh_load),
    .shift_i (sh_shift),
    .data_i  (sh_data),
    .msb_o   (sh_msb)
  );

  // Abort has priority, so a start in the same cycle must not touch the latches.
  assign start_ok = bus.i_Start && !bus.i_Abort && (state_q == IDLE || state_q == DONE);
  assign new_pat  = bus.i_Use_Default ? DEFAULT_PAT : bus.i_Pattern;
  assign sending  = (state_q == SEND);

  // NOTE: every always_comb output gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    gap_len_d = gap_len_q;
    reps_d    = reps_q;
    pat_d     = pat_q;
    sh_load   = 1'b0;
    sh_shift  = 1'b0;
    sh_data   = pat_q;

    case (state_q)
      SEND: begin
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = '0;
          reps_d    = reps_q - 1'b1;
          sh_load   = 1'b1;
          if (reps_q > CNT_W'(1)) begin
            if (gap_len_q != '0) begin
              state_d   = GAP;
              gap_cnt_d = gap_len_q;
            end
          end else begin
            state_d = DONE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          sh_shift  = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_W'(1)) begin
          state_d   = SEND;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (start_ok) begin
      state_d   = SEND;
      bit_cnt_d = '0;
      gap_cnt_d = '0;
      gap_len_d = bus.i_Gap;
      reps_d    = CNT_W'(rep_at_least_one(32'(bus.i_Repeat)));
      pat_d     = new_pat;
      sh_load   = 1'b1;
      sh_data   = new_pat;
    end

    if (bus.i_Abort) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      gap_cnt_d = '0;
      reps_d    = '0;
      sh_load   = 1'b0;
      sh_shift  = 1'b0;
    end
  end

  // Output stage mirrors the current state one edge later; abort idles it at once.
  always_comb begin
    seq_d   = sending ? sh_msb : IDLE_LVL;
    valid_d = sending;
    frame_d = sending && (bit_cnt_q == '0);
    busy_d  = sending || (state_q == GAP);
    done_d  = (state_q == DONE);
    if (bus.i_Abort) begin
      seq_d   = IDLE_LVL;
      valid_d = 1'b0;
      frame_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      gap_len_q <= '0;
      reps_q    <= '0;
      pat_q     <= '0;
      seq_q     <= IDLE_LVL;
      valid_q   <= 1'b0;
      frame_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      gap_len_q <= gap_len_d;
      reps_q    <= reps_d;
      pat_q     <= pat_d;
      seq_q     <= seq_d;
      valid_q   <= valid_d;
      frame_q   <= frame_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.o_Sequence    = seq_q;
  assign bus.o_Valid       = valid_q;
  assign bus.o_Frame_Start = frame_q;
  assign bus.o_Busy        = busy_q;
  assign bus.o_Done        = done_q;
endmodule

// File: tb/tb_serial_sequence_generator.sv
// Self-checking bench: every cycle's outputs are compared with a per-cycle
// expectation list built directly from the pattern/repeat/gap rules.
module tb_serial_sequence_generator;
  localparam int PAT_W = 5;
  localparam int CNT_W = 8;
  localparam int GAP_W = 4;
  localparam logic [PAT_W-1:0] DEF_PAT  = 5'b01110;
  localparam logic             IDLE_LVL = 1'b1;

  // Record layout: {sequence, valid, frame_start, busy, done}
  localparam logic [4:0] IDLE_REC = {IDLE_LVL, 4'b0000};
  localparam logic [4:0] GAP_REC  = {IDLE_LVL, 4'b0010};
  localparam logic [4:0] DONE_REC = {IDLE_LVL, 4'b0001};

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  serial_sequence_generator_if #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

  serial_sequence_generator #(
    .PAT_W(PAT_W), .DEFAULT_PAT(DEF_PAT), .CNT_W(CNT_W), .GAP_W(GAP_W), .IDLE_LVL(IDLE_LVL)
  ) dut (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [4:0] exp_q[$];

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got seq/val/frm/busy/done=%b, expected %b", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [4:0] sample();
    return {bus.o_Sequence, bus.o_Valid, bus.o_Frame_Start, bus.o_Busy, bus.o_Done};
  endfunction

  // Expected output cycles from the first pattern bit through the done pulse.
  task automatic build_expect(input logic [PAT_W-1:0] pat, input int reps, input int gap);
    exp_q.delete();
    for (int r = 0; r < reps; r++) begin
      for (int b = 0; b < PAT_W; b++)
        exp_q.push_back({pat[PAT_W-1-b], 1'b1, (b == 0), 1'b1, 1'b0});
      if (r != reps - 1)
        for (int g = 0; g < gap; g++) exp_q.push_back(GAP_REC);
    end
    exp_q.push_back(DONE_REC);
  endtask

  task automatic drive_start(input logic use_def, input logic [PAT_W-1:0] pat, input int rep, input int gap);
    bus.i_Start       = 1'b1;
    bus.i_Use_Default = use_def;
    bus.i_Pattern     = pat;
    bus.i_Repeat      = CNT_W'(rep);
    bus.i_Gap         = GAP_W'(gap);
  endtask

  // One full transfer. started=1: start was already accepted in the previous
  // transfer's DONE cycle. chain=1: start the next transfer from this DONE cycle.
  task automatic run_txn(input string tag, input logic use_def, input logic [PAT_W-1:0] pat,
                         input int rep, input int gap, input bit started, input bit noise,
                         input bit chain, input logic [PAT_W-1:0] c_pat, input int c_rep,
                         input int c_gap);
    int n;
    int reps;
    reps = (rep == 0) ? 1 : rep;
    build_expect(use_def ? DEF_PAT : pat, reps, gap);
    n = exp_q.size();
    if (!started) begin
      drive_start(use_def, pat, rep, gap);
      @(negedge clk);
      check({tag, "_lat"}, sample(), IDLE_REC);
      bus.i_Start = 1'b0;
      if (noise) begin
        bus.i_Start   = 1'($urandom_range(0, 1));
        bus.i_Pattern = PAT_W'($urandom);
        bus.i_Repeat  = CNT_W'($urandom);
        bus.i_Gap     = GAP_W'($urandom);
      end
    end
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check(tag, sample(), exp_q[k]);
      // Inputs set now are sampled in the state that produces entry k+1.
      bus.i_Start = 1'b0;
      if (noise && (k + 1) < n - 1) begin
        bus.i_Start       = 1'($urandom_range(0, 1));
        bus.i_Use_Default = 1'($urandom_range(0, 1));
        bus.i_Pattern     = PAT_W'($urandom);
        bus.i_Repeat      = CNT_W'($urandom);
        bus.i_Gap         = GAP_W'($urandom);
      end
      if (chain && (k + 1) == n - 1) drive_start(1'b0, c_pat, c_rep, c_gap);
    end
    if (!chain) begin
      @(negedge clk);
      check({tag, "_post"}, sample(), IDLE_REC);
    end
  endtask

  task automatic run_abort(input string tag, input logic [PAT_W-1:0] pat, input int rep,
                           input int gap, input int abort_k);
    build_expect(pat, rep, gap);
    drive_start(1'b0, pat, rep, gap);
    @(negedge clk);
    check({tag, "_lat"}, sample(), IDLE_REC);
    bus.i_Start = 1'b0;
    for (int k = 0; k <= abort_k; k++) begin
      @(negedge clk);
      check(tag, sample(), exp_q[k]);
    end
    bus.i_Abort = 1'b1;
    @(negedge clk);
    check({tag, "_idle"}, sample(), IDLE_REC);
    bus.i_Abort = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check({tag, "_after"}, sample(), IDLE_REC);
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic             r_def, nxt_pending;
    logic [PAT_W-1:0] r_pat, nxt_pat;
    int               r_rep, r_gap, nxt_rep, nxt_gap;
    bit               r_chain;

    bus.i_Start = 1'b0; bus.i_Abort = 1'b0; bus.i_Use_Default = 1'b0;
    bus.i_Pattern = '0; bus.i_Repeat = '0; bus.i_Gap = '0;

    #1 rst_n = 1'b0;
    #1 check("reset_async", sample(), IDLE_REC);
    @(negedge clk);
    @(negedge clk);
    check("reset_held", sample(), IDLE_REC);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_idle", sample(), IDLE_REC);

    run_txn("default_x1", 1'b1, 5'b10101, 1, 0, 0, 0, 0, '0, 0, 0);
    run_txn("p10011_x3_g2", 1'b0, 5'b10011, 3, 2, 0, 0, 0, '0, 0, 0);
    run_txn("default_x2_g0", 1'b1, '0, 2, 0, 0, 0, 0, '0, 0, 0);
    run_txn("rep0_noise", 1'b0, 5'b11001, 0, 3, 0, 1, 0, '0, 0, 0);
    run_txn("gap_max", 1'b0, 5'b00110, 2, 15, 0, 1, 0, '0, 0, 0);
    run_txn("chain_a", 1'b0, 5'b10001, 1, 0, 0, 0, 1, 5'b01011, 2, 1);
    run_txn("chain_b", 1'b0, 5'b01011, 2, 1, 1, 0, 0, '0, 0, 0);
    run_txn("rep_max", 1'b0, 5'b11100, 255, 0, 0, 0, 0, '0, 0, 0);

    // Abort on the 3rd bit of the 2nd repetition, and on the last bit (kills done).
    run_abort("abort_mid", 5'b10011, 3, 2, PAT_W + 2 + 2);
    run_abort("abort_last", 5'b01101, 1, 0, PAT_W - 1);

    bus.i_Start = 1'b1;
    bus.i_Abort = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("start_abort_idle", sample(), IDLE_REC);
    end
    bus.i_Start = 1'b0;
    bus.i_Abort = 1'b0;
    @(negedge clk);
    check("start_abort_idle", sample(), IDLE_REC);

    // Randomized transfers, some started straight from the DONE cycle.
    nxt_pending = 1'b0; nxt_pat = '0; nxt_rep = 0; nxt_gap = 0;
    for (int i = 0; i < 25; i++) begin
      r_chain = ($urandom_range(0, 3) == 0) && (i != 24);
      if (nxt_pending) begin
        r_def = 1'b0; r_pat = nxt_pat; r_rep = nxt_rep; r_gap = nxt_gap;
      end else begin
        r_def = 1'($urandom_range(0, 1));
        r_pat = PAT_W'($urandom);
        r_rep = $urandom_range(0, 4);
        r_gap = $urandom_range(0, 5);
      end
      nxt_pat = PAT_W'($urandom);
      nxt_rep = $urandom_range(0, 3);
      nxt_gap = $urandom_range(0, 3);
      run_txn("random", r_def, r_pat, r_rep, r_gap, nxt_pending, 1, r_chain, nxt_pat, nxt_rep, nxt_gap);
      nxt_pending = r_chain;
    end

    // Asynchronous reset between clock edges in the middle of a pattern.
    build_expect(5'b11010, 2, 1);
    drive_start(1'b0, 5'b11010, 2, 1);
    @(negedge clk);
    check("rst_mid_lat", sample(), IDLE_REC);
    bus.i_Start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_mid_pre", sample(), exp_q[k]);
    end
    #1 rst_n = 1'b0;
    #1 check("rst_mid_async", sample(), IDLE_REC);
    @(negedge clk);
    check("rst_mid_held", sample(), IDLE_REC);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_release", sample(), IDLE_REC);
    run_txn("after_reset", 1'b0, 5'b10110, 1, 0, 0, 0, 0, '0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
